psum_accum_buffer: RTL and testbench
====================================

Name: psum_accum_buffer

Overview:
Parametrised next-generation convolution output buffer. It stores one tile of MAC results per lane and accumulates later input-channel passes into the stored partial sums with a read-modify-write pipeline. It then drains the tile to the activation stage over a valid/ready stream with full backpressure. It sits between the MAC array and the activation/adder-feature path.

Parameters:
LANES, 8, number of parallel output lanes per entry
DATA_W, 36, signed width of one lane value (MAC_OUTPUT_WIDTH)
DEPTH, 32768, entries per lane; power of two
ADDR_W, 15, log2(DEPTH)
RD_LAT, 3, memory read latency in cycles; legal range 1..4
SKID, RD_LAT+2, drain output FIFO depth in entries

Ports:
system_clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
refresh_req  in  1  pulse: clear tile (len<=0, pointers<=0, sticky flags<=0)
feat_valid  in  1  input beat valid; no ready, always accepted unless it is an error case
feat_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
acc_mode  in  1  sampled with feat_valid: 0 = overwrite/append, 1 = accumulate
acc_first  in  1  pulse: restart the accumulate pointer at 0 (start of a new pass)
drain_req  in  1  pulse: stream entries 0..len-1 out
out_valid  out  1  drain data valid
out_ready  in  1  downstream ready
out_data  out  LANES*DATA_W  drained entry
out_last  out  1  high with the final drained entry
drain_busy  out  1  drain pending or active
drain_done  out  1  one-cycle pulse after the last handshake
len  out  ADDR_W+1  entries in the current tile
sat_flag  out  1  sticky: an accumulate saturated
err_flag  out  1  sticky: a beat was dropped

Behaviour:
- Reset: len=0, all pointers=0, out_valid=0, out_last=0, drain_busy=0, drain_done=0, sat_flag=0, err_flag=0, skid FIFO empty. Memory contents are not reset.
- Overwrite beat (acc_mode=0): write feat_data at wr_ptr the same cycle. wr_ptr++, len++.
- Overwrite beat at len==DEPTH: dropped, err_flag<=1.
- Accumulate beat (acc_mode=1): issue a read at acc_ptr. After RD_LAT cycles, write back the per-lane signed sum with saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets sat_flag. acc_ptr++.
- Accumulate beat with acc_ptr>=len: dropped, err_flag<=1.
- Back-to-back accumulate beats are sustained at 1/cycle. Addresses within a pass are unique, so the pipeline has no RAW hazard.
- Any feat_valid while drain_busy=1: dropped, err_flag<=1.
- A write-back and an overwrite in the same cycle cannot occur; the next item defines the required handling.
- An overwrite beat while accumulate write-backs are in flight is dropped with err_flag<=1.
- acc_first: acc_ptr<=0; it takes priority over a same-cycle beat increment. The beat itself uses the old pointer.
- refresh_req: highest priority. Aborts any drain (out_valid<=0, FIFO flushed, drain_busy<=0, no drain_done). In-flight write-backs are discarded.
- Drain states:
  - IDLE to WAIT on drain_req. drain_busy=1 from the next cycle.
  - WAIT until the accumulate pipeline is empty, then to RUN.
  - RUN issues reads rd_ptr=0..len-1. A read is issued only when fifo_count + reads_in_flight < SKID (credit rule), so data is never lost.
  - The FIFO head drives out_data/out_valid. Data is held stable while out_valid && !out_ready.
  - Once the last handshake completes, go to IDLE and pulse drain_done.
- len==0 drain: no out_valid; drain_done pulses 1 cycle after leaving WAIT.
- drain_req while drain_busy: ignored.
- Drain throughput with out_ready=1: 1 entry/cycle after initial latency RD_LAT+1 from RUN entry.
- Draining does not clear len; the tile can be re-drained.

Test Plan:
- Reset, then 4 overwrite beats with lane values k*10+i (k = beat index, i = lane index), then drain with out_ready=1 -> 4 beats in order, out_last on beat 3, drain_done 1 cycle later, len=4.
- Overwrite 3 beats, then acc_first plus 3 accumulate beats adding 1 to every lane, then drain -> every lane equals original+1, sat_flag=0.
- Lane 0 = 2^35-2 (2^(DATA_W-1)-2 for DATA_W=36) accumulated with +5 -> drains as 2^35-1, sat_flag=1; a negative overflow clamps to -2^35.
- Drain of 16 entries with out_ready toggling 1010... and a 10-cycle stall -> no loss or duplication, out_data stable during stalls, FIFO never overflows.
- Drain of len=0 -> no out_valid, drain_done pulse. feat_valid during a drain -> beat dropped, err_flag=1.
- refresh_req mid-drain after 5 of 10 beats -> out_valid=0 next cycle, drain_busy=0, no drain_done, len=0.

Source files
------------

// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: per-lane partial-sum tile buffer. Overwrite beats append
// MAC results; accumulate beats read-modify-write saturating sums into the
// stored tile; a credit-controlled drain streams the tile out over valid/ready.

// Per-lane signed saturating adder used on the accumulate write-back path.
module psum_lane_sat #(
  parameter int DATA_W = 36
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum_val,
  output logic              sat
);
  logic [DATA_W:0] wide;

  // One guard bit; top two bits disagreeing means the true sum left the range.
  always_comb begin
    wide    = {old_val[DATA_W-1], old_val} + {add_val[DATA_W-1], add_val};
    sat     = wide[DATA_W] ^ wide[DATA_W-1];
    sum_val = wide[DATA_W-1:0];
    if (sat) sum_val = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

module psum_accum_buffer #(
  parameter int LANES  = 8,
  parameter int DATA_W = 36,
  parameter int DEPTH  = 32768,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 3,
  parameter int SKID   = RD_LAT + 2
) (
  input  logic                    system_clk,
  input  logic                    rst_n,
  input  logic                    refresh_req,
  input  logic                    feat_valid,
  input  logic [LANES*DATA_W-1:0] feat_data,
  input  logic                    acc_mode,
  input  logic                    acc_first,
  input  logic                    drain_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    drain_busy,
  output logic                    drain_done,
  output logic [ADDR_W:0]         len,
  output logic                    sat_flag,
  output logic                    err_flag
);
  localparam int ENT_W = LANES * DATA_W;
  localparam int FP_W  = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int FC_W  = $clog2(SKID + 1);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} drain_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ENT_W-1:0]  add;
  } acc_req_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] fifo_mem [SKID];

  drain_state_t state_q, state_d;
  logic [ADDR_W:0]   acc_ptr, rd_ptr, out_cnt;
  logic [RD_LAT-1:0] acc_vld_pipe, drn_vld_pipe;
  acc_req_t [RD_LAT-1:0] acc_pipe;
  logic [RD_LAT-1:0][ENT_W-1:0] rd_pipe;
  logic [FP_W-1:0]   fifo_head, fifo_tail;
  logic [FC_W-1:0]   fifo_cnt;

  logic acc_busy, beat_wr, beat_acc, beat_err, drn_issue, wb_en;
  logic push, pop, finish, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [ENT_W-1:0]  wr_data;
  logic [LANES-1:0][DATA_W-1:0] wb_lanes;
  logic [LANES-1:0]  lane_sat;

  function automatic logic [FP_W-1:0] fifo_nxt(input logic [FP_W-1:0] p);
    return (p == FP_W'(SKID - 1)) ? '0 : p + FP_W'(1);
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_lane_sat #(.DATA_W(DATA_W)) u_sat (
      .old_val (rd_pipe[RD_LAT-1][i*DATA_W +: DATA_W]),
      .add_val (acc_pipe[RD_LAT-1].add[i*DATA_W +: DATA_W]),
      .sum_val (wb_lanes[i]),
      .sat     (lane_sat[i])
    );
  end

  assign drain_busy = (state_q != S_IDLE);
  assign out_valid  = (fifo_cnt != '0);
  assign out_data   = fifo_mem[fifo_head];
  assign out_last   = out_valid && (out_cnt == len - ONE);

  // Beat acceptance, drain read credit and shared memory port steering.
  // The write address for appends is len itself: the append pointer and the
  // tile length always move together.
  always_comb begin
    acc_busy  = |acc_vld_pipe;
    beat_wr   = feat_valid && !refresh_req && !drain_busy && !acc_mode &&
                (len != LEN_FULL) && !acc_busy;
    beat_acc  = feat_valid && !refresh_req && !drain_busy && acc_mode &&
                (acc_ptr < len);
    beat_err  = feat_valid && !refresh_req && !beat_wr && !beat_acc;
    drn_issue = (state_q == S_RUN) && (rd_ptr < len) &&
                ((int'(fifo_cnt) + $countones(drn_vld_pipe)) < SKID);
    wb_en     = acc_vld_pipe[RD_LAT-1] && !refresh_req;
    push      = drn_vld_pipe[RD_LAT-1];
    pop       = out_valid && out_ready;
    finish    = (state_q == S_RUN) && ((pop && out_last) || (len == '0));
    rd_en     = beat_acc || drn_issue;
    rd_addr   = beat_acc ? acc_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
    wr_en     = beat_wr || wb_en;
    wr_addr   = beat_wr ? len[ADDR_W-1:0] : acc_pipe[RD_LAT-1].addr;
    wr_data   = beat_wr ? feat_data : wb_lanes;
  end

  // Drain FSM next state; refresh aborts from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (drain_req) state_d = S_WAIT;
      S_WAIT:  if (!acc_busy) state_d = S_RUN;
      S_RUN:   if (finish)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (refresh_req) state_d = S_IDLE;
  end

  // Drain FSM state register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Control state: pointers, length, sticky flags, valid pipes, FIFO pointers.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0; acc_ptr <= '0; rd_ptr <= '0; out_cnt <= '0;
      sat_flag <= 1'b0; err_flag <= 1'b0; drain_done <= 1'b0;
      acc_vld_pipe <= '0; drn_vld_pipe <= '0;
      fifo_head <= '0; fifo_tail <= '0; fifo_cnt <= '0;
    end else if (refresh_req) begin
      len <= '0; acc_ptr <= '0; rd_ptr <= '0; out_cnt <= '0;
      sat_flag <= 1'b0; err_flag <= 1'b0; drain_done <= 1'b0;
      acc_vld_pipe <= '0; drn_vld_pipe <= '0;
      fifo_head <= '0; fifo_tail <= '0; fifo_cnt <= '0;
    end else begin
      drain_done <= finish;
      if (beat_wr) len <= len + ONE;
      if (acc_first)     acc_ptr <= '0;
      else if (beat_acc) acc_ptr <= acc_ptr + ONE;
      if (beat_err) err_flag <= 1'b1;
      if (wb_en && |lane_sat) sat_flag <= 1'b1;
      acc_vld_pipe[0] <= beat_acc;
      drn_vld_pipe[0] <= drn_issue;
      for (int k = 1; k < RD_LAT; k++) begin
        acc_vld_pipe[k] <= acc_vld_pipe[k-1];
        drn_vld_pipe[k] <= drn_vld_pipe[k-1];
      end
      if (state_q == S_IDLE && drain_req) begin
        rd_ptr  <= '0;
        out_cnt <= '0;
      end else begin
        if (drn_issue) rd_ptr  <= rd_ptr + ONE;
        if (pop)       out_cnt <= out_cnt + ONE;
      end
      if (push) fifo_tail <= fifo_nxt(fifo_tail);
      if (pop)  fifo_head <= fifo_nxt(fifo_head);
      fifo_cnt <= fifo_cnt + FC_W'(push) - FC_W'(pop);
    end
  end

  // Datapath: tile memory, read-latency delay line, accumulate operands, FIFO storage.
  always_ff @(posedge system_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_pipe[0] <= mem[rd_addr];
    acc_pipe[0] <= '{addr: acc_ptr[ADDR_W-1:0], add: feat_data};
    for (int k = 1; k < RD_LAT; k++) begin
      rd_pipe[k]  <= rd_pipe[k-1];
      acc_pipe[k] <= acc_pipe[k-1];
    end
    if (push) fifo_mem[fifo_tail] <= rd_pipe[RD_LAT-1];
  end
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: a bench-side tile model produces the
// expected drain stream, which the output monitor pops and compares.
module tb_psum_accum_buffer;
  localparam int LANES = 8, DATA_W = 36, DEPTH = 32, ADDR_W = 5, RD_LAT = 3;
  localparam int W = LANES * DATA_W;
  localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));

  logic clk = 1'b0;
  logic rst_n, refresh_req, feat_valid, acc_mode, acc_first, drain_req, out_ready;
  logic [W-1:0] feat_data, out_data;
  logic out_valid, out_last, drain_busy, drain_done, sat_flag, err_flag;
  logic [ADDR_W:0] len;

  psum_accum_buffer #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .system_clk(clk), .rst_n(rst_n), .refresh_req(refresh_req),
    .feat_valid(feat_valid), .feat_data(feat_data), .acc_mode(acc_mode),
    .acc_first(acc_first), .drain_req(drain_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .drain_busy(drain_busy), .drain_done(drain_done), .len(len),
    .sat_flag(sat_flag), .err_flag(err_flag));

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_base = 0, vld_cnt = 0;
  int hs_in_drain = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic held = 1'b0;
  logic [W-1:0] held_data;

  logic [W-1:0] m_mem [DEPTH];
  int m_len = 0, m_acc = 0;
  logic m_sat = 1'b0, m_err = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: stability while stalled, scoreboard pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      vld_cnt++;
      if (held) chk("stall_stable", out_data, held_data);
      if (out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.data);
          chk("last", out_last, e.last);
        end
        if (hs_in_drain == 0) first_hs_cyc = cyc;
        hs_in_drain++;
        last_hs_cyc = cyc;
      end else begin
        held = 1'b1;
        held_data = out_data;
      end
    end else held = 1'b0;
    if (drain_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DATA_W:0] sadd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > MAXV) return {1'b1, DATA_W'(MAXV)};
    if (s < MINV) return {1'b1, DATA_W'(MINV)};
    return {1'b0, DATA_W'(s)};
  endfunction

  function automatic logic [W-1:0] mk(input int k);
    logic [LANES-1:0][DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i] = DATA_W'(k * 10 + i);
    return v;
  endfunction

  function automatic logic [W-1:0] splat(input longint x);
    logic [LANES-1:0][DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i] = DATA_W'(x);
    return v;
  endfunction

  function automatic logic rdy_pat(input int c);
    return (c >= 6 && c < 16) ? 1'b0 : (c % 2 == 0);
  endfunction

  task automatic refresh();
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    m_len = 0; m_acc = 0; m_sat = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  // One input beat; the model applies the same acceptance rules, with
  // force_drop covering cases only the stimulus knows about (drain, in-flight).
  task automatic beat(input logic mode, input logic [W-1:0] d, input bit first, input bit force_drop);
    logic [LANES-1:0][DATA_W-1:0] cur, add;
    logic [DATA_W:0] r;
    feat_valid = 1'b1; acc_mode = mode; feat_data = d; acc_first = first;
    tick();
    feat_valid = 1'b0; acc_mode = 1'b0; acc_first = 1'b0;
    if (force_drop) m_err = 1'b1;
    else if (!mode) begin
      if (m_len < DEPTH) begin m_mem[m_len] = d; m_len++; end
      else m_err = 1'b1;
    end else begin
      if (m_acc < m_len) begin
        cur = m_mem[m_acc]; add = d;
        for (int i = 0; i < LANES; i++) begin
          r = sadd(cur[i], add[i]);
          cur[i] = r[DATA_W-1:0];
          if (r[DATA_W]) m_sat = 1'b1;
        end
        m_mem[m_acc] = cur;
        m_acc++;
      end else m_err = 1'b1;
    end
    if (first) m_acc = 0;
  endtask

  task automatic first_pulse();
    acc_first = 1'b1; tick(); acc_first = 1'b0; m_acc = 0;
  endtask

  task automatic drain_start();
    exp_t e;
    for (int k = 0; k < m_len; k++) begin
      e.data = m_mem[k]; e.last = (k == m_len - 1);
      exp_q.push_back(e);
    end
    hs_in_drain = 0; done_base = done_cnt;
    drain_req = 1'b1; tick(); drain_req = 1'b0;
  endtask

  task automatic drain_wait(input bit pat, input int max_cyc, input bit chk_tp);
    int c = 0;
    while (done_cnt == done_base && c < max_cyc) begin
      out_ready = pat ? rdy_pat(c) : 1'b1;
      tick(); c++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", (c < max_cyc), 1);
    chk("drain_left", exp_q.size(), 0);
    chk("busy_after", drain_busy, 0);
    chk("len", len, m_len);
    if (m_len > 0) chk("done_gap", done_cyc - last_hs_cyc, 1);
    if (chk_tp && m_len > 0) chk("throughput", last_hs_cyc - first_hs_cyc, m_len - 1);
  endtask

  initial begin
    int c, d0, v0;
    logic [LANES-1:0][DATA_W-1:0] v;
    rst_n = 1'b0; refresh_req = 1'b0; feat_valid = 1'b0; acc_mode = 1'b0;
    acc_first = 1'b0; drain_req = 1'b0; out_ready = 1'b1; feat_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_len", len, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_err", err_flag, 0);

    // 4 overwrites k*10+i, drain at full rate, then re-drain the same tile.
    for (int k = 0; k < 4; k++) beat(1'b0, mk(k), 0, 0);
    drain_start(); drain_wait(0, 100, 1);
    drain_start(); drain_wait(0, 100, 1);

    // Overwrite 3, two accumulate passes of +1 (second after acc_first).
    refresh();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = DATA_W'($urandom_range(0, 1000));
      beat(1'b0, v, 0, 0);
    end
    first_pulse();
    for (int k = 0; k < 3; k++) beat(1'b1, splat(1), 0, 0);
    first_pulse();
    for (int k = 0; k < 3; k++) beat(1'b1, splat(1), 0, 0);
    drain_start(); drain_wait(0, 100, 1);
    chk("acc_sat_clear", sat_flag, m_sat);
    chk("acc_err_clear", err_flag, m_err);

    // Saturation at both rails on lane 0.
    refresh();
    v = mk(0); v[0] = DATA_W'(MAXV - 1); beat(1'b0, v, 0, 0);
    v = mk(1); v[0] = DATA_W'(MINV + 1); beat(1'b0, v, 0, 0);
    repeat (RD_LAT + 2) tick();
    chk("sat_before", sat_flag, 0);
    v = splat(0); v[0] = DATA_W'(longint'(5));  beat(1'b1, v, 0, 0);
    v = splat(0); v[0] = DATA_W'(-longint'(7)); beat(1'b1, v, 0, 0);
    repeat (RD_LAT + 2) tick();
    chk("sat_after", sat_flag, m_sat);
    drain_start(); drain_wait(0, 100, 1);

    // 16 entries with 1010 ready pattern and a 10-cycle stall.
    refresh();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = DATA_W'($urandom);
      beat(1'b0, v, 0, 0);
    end
    drain_start(); drain_wait(1, 300, 0);

    // Empty drain: no valid, single done pulse.
    refresh();
    v0 = vld_cnt; d0 = done_cnt;
    drain_start(); drain_wait(0, 50, 0);
    chk("empty_no_valid", vld_cnt - v0, 0);
    chk("empty_done_once", done_cnt - d0, 1);

    // Beat during a drain is dropped.
    refresh();
    beat(1'b0, mk(3), 0, 0); beat(1'b0, mk(4), 0, 0);
    drain_start();
    beat(1'b0, mk(9), 0, 1);
    drain_wait(0, 100, 1);
    chk("drop_in_drain_err", err_flag, m_err);

    // Overwrite at len==DEPTH is dropped.
    refresh();
    for (int k = 0; k <= DEPTH; k++) beat(1'b0, mk(k), 0, 0);
    chk("full_len", len, m_len);
    chk("full_err", err_flag, m_err);

    // Accumulate past len dropped; acc_first with a beat uses the old pointer;
    // overwrite while a write-back is in flight dropped.
    refresh();
    beat(1'b0, mk(1), 0, 0); beat(1'b0, mk(2), 0, 0);
    first_pulse();
    beat(1'b1, splat(1), 0, 0);
    beat(1'b1, splat(2), 1, 0);
    repeat (RD_LAT + 1) tick();
    beat(1'b1, splat(4), 0, 0);
    beat(1'b0, mk(7), 0, 1);
    repeat (RD_LAT + 1) tick();
    chk("inflight_len", len, m_len);
    beat(1'b1, splat(8), 0, 0);
    beat(1'b1, splat(8), 0, 0);
    repeat (RD_LAT + 1) tick();
    chk("acc_over_err", err_flag, m_err);
    drain_start(); drain_wait(0, 100, 1);

    // Refresh after 5 of 10 drained beats aborts the drain.
    refresh();
    for (int k = 0; k < 10; k++) beat(1'b0, mk(k + 20), 0, 0);
    drain_start();
    d0 = done_cnt; c = 0;
    while (hs_in_drain < 5 && c < 100) begin out_ready = 1'b1; tick(); c++; end
    chk("abort_reach5", (c < 100), 1);
    out_ready = 1'b0; refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", drain_busy, 0);
    chk("abort_len", len, 0);
    out_ready = 1'b1;
    repeat (12) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_beats", hs_in_drain, 5);
    exp_q.delete();
    m_len = 0; m_acc = 0; m_sat = 1'b0; m_err = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
